// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Per-bit synchroniser and debouncer for the DE10-Lite slide switches. It sits
// in front of the switch-driven datapath, for example the 4:1 LED mux whose
// data and select lines come from SW. Downstream logic receives clean levels
// aligned to clk, plus one-cycle strobes on each accepted edge.
//
// Parameters
//   WIDTH            number of independent switch bits
//   DEBOUNCE_CYCLES  consecutive cycles a new level must hold at the
//                    synchroniser output before it is accepted (>= 1)
//   CNT_W            per-bit counter width; derived, leave at default
//
// Ports
//   clk      in   1      system clock
//   reset    in   1      synchronous, active-high reset
//   sw_in    in   WIDTH  raw asynchronous switch inputs
//   sw_db    out  WIDTH  debounced, registered switch levels
//   sw_rise  out  WIDTH  one-cycle pulse per bit on an accepted 0->1 change
//   sw_fall  out  WIDTH  one-cycle pulse per bit on an accepted 1->0 change
//   changed  out  1      registered OR of all sw_rise|sw_fall bits, same cycle
//
// Every output comes from a flop, so sw_in has no combinational path to any
// output.
// -----------------------------------------------------------------------------
module switch_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed
);

    // Terminal count. When a bit reaches this value and still disagrees with
    // sw_db, the new level is accepted on the same edge. The counter therefore
    // never passes this value and cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Two-flop synchroniser. The stages are connected directly, with no logic
    // between them, so s1 has a full clock period to resolve metastability.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= sw_in;
            s2_reg <= s1_reg;
        end
    end

    // Next-state strobes from every bit. They are collected here so that
    // 'changed' can be registered from the same values, which keeps it
    // cycle-aligned with sw_rise/sw_fall.
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    // -------------------------------------------------------------------------
    // Independent debounce slice per bit
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;
        logic             db_reg;
        logic             db_next;
        logic             rise_reg;
        logic             rise_nx;
        logic             fall_reg;
        logic             fall_nx;

        always_comb begin
            cnt_next = cnt_reg;
            db_next  = db_reg;
            rise_nx  = 1'b0;
            fall_nx  = 1'b0;
            if (s2_reg[gi] == db_reg) begin
                // Input agrees with the accepted level. A bounce back to the
                // old level lands here and discards the partial count.
                cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
                // The new level has disagreed on DEBOUNCE_CYCLES consecutive
                // edges, so accept it now.
                db_next  = s2_reg[gi];
                cnt_next = '0;
                rise_nx  = s2_reg[gi];
                fall_nx  = ~s2_reg[gi];
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_reg  <= '0;
                db_reg   <= 1'b0;
                rise_reg <= 1'b0;
                fall_reg <= 1'b0;
            end else begin
                cnt_reg  <= cnt_next;
                db_reg   <= db_next;
                rise_reg <= rise_nx;
                fall_reg <= fall_nx;
            end
        end

        assign rise_next[gi] = rise_nx;
        assign fall_next[gi] = fall_nx;
        assign sw_db[gi]     = db_reg;
        assign sw_rise[gi]   = rise_reg;
        assign sw_fall[gi]   = fall_reg;
    end

    // -------------------------------------------------------------------------
    // Aggregate change flag. When several bits change in the same cycle they
    // produce a single pulse here.
    // -------------------------------------------------------------------------
    logic changed_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= |(rise_next | fall_next);
        end
    end

    assign changed = changed_reg;

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
//
// Scoreboard bench for switch_debounce, using WIDTH=10 and DEBOUNCE_CYCLES=4.
// At every clock edge a reference model predicts the registered outputs and
// pushes them into a queue. A separate monitor pops one entry at each falling
// edge and compares it with the DUT.
//
// The reference model accepts a new level for a bit when the last
// DEBOUNCE_CYCLES synchronised samples all disagree with the current
// debounced level. It evaluates this as a sliding window over a sample
// history rather than with a per-bit counter.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

    localparam int W = 10;
    localparam int D = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] sw_in;
    logic [W-1:0] sw_db;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         changed;

    int checks = 0;
    int errors = 0;

    switch_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sw_in  (sw_in),
        .sw_db  (sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .changed(changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model + scoreboard queue ----------------
    typedef struct packed {
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } exp_t;

    exp_t exp_q[$];

    logic [W-1:0] m_s1  = '0;
    logic [W-1:0] m_s2  = '0;
    logic [W-1:0] m_db  = '0;
    logic [W-1:0] m_hist [D];  // synchronised samples; [0] is the newest

    initial begin
        for (int j = 0; j < D; j++) m_hist[j] = '0;
    end

    always @(posedge clk) begin
        exp_t         e;
        logic [W-1:0] mask;
        if (reset) begin
            m_s1 = '0;
            m_s2 = '0;
            m_db = '0;
            for (int j = 0; j < D; j++) m_hist[j] = '0;
            e = '0;
        end else begin
            for (int j = D - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = m_s2;
            mask = '1;
            for (int j = 0; j < D; j++) mask = mask & (m_hist[j] ^ m_db);
            e.rise = mask & ~m_db;
            e.fall = mask & m_db;
            m_db   = m_db ^ mask;
            e.db   = m_db;
            e.chg  = |mask;
            m_s2   = m_s1;
            m_s1   = sw_in;
        end
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 4;
            if (sw_db !== e.db) begin
                errors++;
                $display("FAIL sw_db at %0t: got %h expected %h", $time, sw_db, e.db);
            end
            if (sw_rise !== e.rise) begin
                errors++;
                $display("FAIL sw_rise at %0t: got %h expected %h", $time, sw_rise, e.rise);
            end
            if (sw_fall !== e.fall) begin
                errors++;
                $display("FAIL sw_fall at %0t: got %h expected %h", $time, sw_fall, e.fall);
            end
            if (changed !== e.chg) begin
                errors++;
                $display("FAIL changed at %0t: got %b expected %b", $time, changed, e.chg);
            end
            if (changed === 1'b1)
                $display("event t=%0t db=%h rise=%h fall=%h", $time, sw_db, sw_rise, sw_fall);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Releases reset and counts the edges until sw_db[bit] becomes 1.
    // The bound is 12 edges.
    task automatic release_and_measure(input int bit_i, input string name);
        int found;
        found = 0;
        reset = 1'b0;
        for (int k = 1; k <= 12 && found == 0; k++) begin
            @(posedge clk);
            #1;
            if (sw_db[bit_i] === 1'b1) found = k;
        end
        checks++;
        if (found != D + 2) begin
            errors++;
            $display("FAIL %s latency: got %0d edges required %0d", name, found, D + 2);
        end else begin
            $display("%s: sw_db[%0d] accepted after %0d edges", name, bit_i, found);
        end
        @(negedge clk);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        reset = 1'b1;
        sw_in = '1;
        cyc(3);

        // 1: switches held high through reset
        release_and_measure(0, "reset_held");
        cyc(4);

        // 2: clean rising edge on bit 0
        sw_in = '0;
        cyc(10);
        sw_in = 10'h001;
        cyc(10);

        // 3: bounce on bit 3, then settle high
        for (int b = 0; b < 4; b++) begin
            sw_in[3] = ~sw_in[3];
            cyc(2);
        end
        sw_in[3] = 1'b1;
        cyc(10);

        // 4: glitch on bit 5 that is too short to be accepted
        sw_in[5] = 1'b1;
        cyc(3);
        sw_in[5] = 1'b0;
        cyc(10);

        // 5: simultaneous rises on 3:0 and fall on bit 9
        sw_in = 10'h200;
        cyc(10);
        sw_in = 10'h00F;
        cyc(10);

        // 6: reset while bit 2 is part-way through its count
        sw_in = '0;
        cyc(10);
        sw_in[2] = 1'b1;
        cyc(4);
        reset = 1'b1;
        cyc(2);
        release_and_measure(2, "reset_midcount");
        cyc(4);

        // Random: mostly slow toggles, some bursts of bounce, rare resets
        for (int t = 0; t < 3000; t++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 19) == 0) sw_in[b] = ~sw_in[b];
            end
            if ($urandom_range(0, 99) < 5) sw_in = sw_in ^ W'($urandom_range(0, 1023));
            reset = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        reset = 1'b0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
